// File: rtl/uart_receiver.sv
// uart_receiver
//   Oversampling UART receiver: one start bit, DATA_SIZE data bits (LSB
//   first), one stop bit. The line is sampled at mid-bit using a sample tick
//   derived from clk. A received word is held in dout with a level valid flag
//   until the consumer acknowledges it.
//
// Ports
//   clk         in   system clock, rising edge
//   reset_n     in   asynchronous active-low reset
//   rx          in   asynchronous serial line, idle high
//   dout        out  last accepted data word
//   recv_valid  out  dout holds a word not yet acknowledged
//   recv_ack    in   consumer takes dout while recv_valid is high
//   frame_err   out  one-cycle pulse, stop bit sampled low
//   overrun_err out  one-cycle pulse, good word lost because dout was still full
module uart_receiver #(
  parameter int SYS_FREQ  = 50000000,
  parameter int BAUD_RATE = 9600,
  parameter int SAMPLE    = 16,
  parameter int BAUD_DV   = SYS_FREQ / (SAMPLE * BAUD_RATE),
  parameter int DATA_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 rx,
  output logic [DATA_SIZE-1:0] dout,
  output logic                 recv_valid,
  input  logic                 recv_ack,
  output logic                 frame_err,
  output logic                 overrun_err
);

  localparam int TICK_W = $clog2(BAUD_DV);
  localparam int SAMP_W = $clog2(SAMPLE);
  localparam int BIT_W  = $clog2(DATA_SIZE + 1);

  localparam logic [TICK_W-1:0] TICK_LAST      = TICK_W'(BAUD_DV - 1);
  localparam logic [TICK_W-1:0] TICK_ONE       = TICK_W'(1);
  localparam logic [SAMP_W-1:0] SAMP_HALF_LAST = SAMP_W'(SAMPLE / 2 - 1);
  localparam logic [SAMP_W-1:0] SAMP_LAST      = SAMP_W'(SAMPLE - 1);
  localparam logic [SAMP_W-1:0] SAMP_ONE       = SAMP_W'(1);
  localparam logic [BIT_W-1:0]  BIT_LAST       = BIT_W'(DATA_SIZE - 1);
  localparam logic [BIT_W-1:0]  BIT_FULL       = BIT_W'(DATA_SIZE);
  localparam logic [BIT_W-1:0]  BIT_ONE        = BIT_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic                 rx_meta_q, rx_meta_d;
  logic                 rx_sync_q, rx_sync_d;
  logic                 line_idle_seen_q, line_idle_seen_d;
  logic [TICK_W-1:0]    tick_cnt_q, tick_cnt_d;
  logic [SAMP_W-1:0]    samp_cnt_q, samp_cnt_d;
  logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_SIZE-1:0] shift_q, shift_d;
  logic [DATA_SIZE-1:0] dout_q, dout_d;
  logic                 recv_valid_q, recv_valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_err_q, overrun_err_d;

  logic rx_s;
  logic tick_s;
  logic mid_start_s;
  logic mid_bit_s;
  logic stop_sample_s;
  logic load_s;

  assign rx_s          = rx_sync_q;
  assign tick_s        = (tick_cnt_q == TICK_LAST);
  assign mid_start_s   = (state_q == START) && tick_s && (samp_cnt_q == SAMP_HALF_LAST);
  assign mid_bit_s     = tick_s && (samp_cnt_q == SAMP_LAST);
  assign stop_sample_s = (state_q == STOP) && mid_bit_s;
  // A good stop bit is taken when dout is free or being freed this very cycle.
  assign load_s        = stop_sample_s && rx_s && (!recv_valid_q || recv_ack);

  assign dout        = dout_q;
  assign recv_valid  = recv_valid_q;
  assign frame_err   = frame_err_q;
  assign overrun_err = overrun_err_q;

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q          <= IDLE;
      rx_meta_q        <= 1'b1;
      rx_sync_q        <= 1'b1;
      line_idle_seen_q <= 1'b0;
      tick_cnt_q       <= '0;
      samp_cnt_q       <= '0;
      bit_cnt_q        <= '0;
      shift_q          <= '0;
      dout_q           <= '0;
      recv_valid_q     <= 1'b0;
      frame_err_q      <= 1'b0;
      overrun_err_q    <= 1'b0;
    end else begin
      state_q          <= state_d;
      rx_meta_q        <= rx_meta_d;
      rx_sync_q        <= rx_sync_d;
      line_idle_seen_q <= line_idle_seen_d;
      tick_cnt_q       <= tick_cnt_d;
      samp_cnt_q       <= samp_cnt_d;
      bit_cnt_q        <= bit_cnt_d;
      shift_q          <= shift_d;
      dout_q           <= dout_d;
      recv_valid_q     <= recv_valid_d;
      frame_err_q      <= frame_err_d;
      overrun_err_q    <= overrun_err_d;
    end
  end

  // Next-state logic of the frame FSM.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        // Only start once the line has been seen idle since reset.
        if (line_idle_seen_q && !rx_s) begin
          state_d = START;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        if (mid_start_s) begin
          state_d = rx_s ? IDLE : DATA;
        end else begin
          state_d = START;
        end
      end
      DATA: begin
        if (mid_bit_s && (bit_cnt_q == BIT_LAST)) begin
          state_d = STOP;
        end else begin
          state_d = DATA;
        end
      end
      STOP: begin
        // Leave on the mid-stop sample so a following start edge is not missed.
        if (mid_bit_s) begin
          state_d = IDLE;
        end else begin
          state_d = STOP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Counters, shift register and registered outputs.
  always_comb begin
    rx_meta_d        = rx;
    rx_sync_d        = rx_meta_q;
    line_idle_seen_d = line_idle_seen_q | rx_s;
    tick_cnt_d       = tick_cnt_q;
    samp_cnt_d       = samp_cnt_q;
    bit_cnt_d        = bit_cnt_q;
    shift_d          = shift_q;

    if (state_q == IDLE) begin
      tick_cnt_d = '0;
    end else if (tick_s) begin
      tick_cnt_d = '0;
    end else begin
      tick_cnt_d = tick_cnt_q + TICK_ONE;
    end

    case (state_q)
      IDLE: begin
        samp_cnt_d = '0;
        bit_cnt_d  = '0;
      end
      START: begin
        if (mid_start_s) begin
          samp_cnt_d = '0;
        end else if (tick_s) begin
          samp_cnt_d = samp_cnt_q + SAMP_ONE;
        end else begin
          samp_cnt_d = samp_cnt_q;
        end
      end
      DATA, STOP: begin
        if (mid_bit_s) begin
          samp_cnt_d = '0;
        end else if (tick_s) begin
          samp_cnt_d = samp_cnt_q + SAMP_ONE;
        end else begin
          samp_cnt_d = samp_cnt_q;
        end
        // LSB arrives first: enter at the MSB and shift right.
        if ((state_q == DATA) && mid_bit_s && (bit_cnt_q != BIT_FULL)) begin
          shift_d   = {rx_s, shift_q[DATA_SIZE-1:1]};
          bit_cnt_d = bit_cnt_q + BIT_ONE;
        end else begin
          shift_d   = shift_q;
          bit_cnt_d = bit_cnt_q;
        end
      end
      default: begin
        samp_cnt_d = '0;
        bit_cnt_d  = '0;
      end
    endcase

    frame_err_d   = stop_sample_s && !rx_s;
    overrun_err_d = stop_sample_s && rx_s && recv_valid_q && !recv_ack;

    if (load_s) begin
      dout_d       = shift_q;
      recv_valid_d = 1'b1;
    end else if (recv_valid_q && recv_ack) begin
      dout_d       = dout_q;
      recv_valid_d = 1'b0;
    end else begin
      dout_d       = dout_q;
      recv_valid_d = recv_valid_q;
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver at 64 clk per bit (BAUD_DV=4, SAMPLE=16).
// Frames are driven bit-aligned to clk; expectations are hand computed:
// a frame whose start bit is driven right after edge P0 has its mid-stop
// sample at edge P0+611 (2 sync flops + 1 idle decode + (8 + 9*16) ticks * 4).
module tb_uart_receiver;

  localparam int BIT_CLKS = 64;
  localparam int STOP_LAT = 611;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       rx;
  logic       recv_ack;
  logic [7:0] dout;
  logic       recv_valid;
  logic       frame_err;
  logic       overrun_err;

  int checks    = 0;
  int errors    = 0;
  int cyc       = 0;
  int ferr_cnt  = 0;
  int oerr_cnt  = 0;
  int rise_cyc  = -1;
  int start_cyc = 0;
  logic valid_prev = 1'b0;

  uart_receiver #(
    .SYS_FREQ (640),
    .BAUD_RATE(10),
    .SAMPLE   (16),
    .BAUD_DV  (4),
    .DATA_SIZE(8)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .rx         (rx),
    .dout       (dout),
    .recv_valid (recv_valid),
    .recv_ack   (recv_ack),
    .frame_err  (frame_err),
    .overrun_err(overrun_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse counters and recv_valid rising-edge timestamp, sampled mid-cycle.
  always @(negedge clk) begin
    if (frame_err)   ferr_cnt <= ferr_cnt + 1;
    if (overrun_err) oerr_cnt <= oerr_cnt + 1;
    if (recv_valid && !valid_prev) rise_cyc <= cyc;
    valid_prev <= recv_valid;
  end

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Caller is 1 time unit after a rising edge; returns likewise.
  task automatic send_frame(input logic [7:0] data, input logic stop_bit, input logic ack_at_stop);
    start_cyc = cyc;
    rx = 1'b0;
    repeat (BIT_CLKS) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      rx = data[i];
      repeat (BIT_CLKS) @(posedge clk);
      #1;
    end
    rx = stop_bit;
    repeat (34) @(posedge clk);
    #1;
    if (ack_at_stop) recv_ack = 1'b1;
    @(posedge clk);
    #1;
    recv_ack = 1'b0;
    repeat (29) @(posedge clk);
    #1;
    rx = 1'b1;
  endtask

  task automatic do_ack();
    recv_ack = 1'b1;
    @(posedge clk);
    #1;
    recv_ack = 1'b0;
  endtask

  task automatic test_reset();
    reset_n  = 1'b0;
    rx       = 1'b1;
    recv_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (dout !== 8'h00) begin errors++; $display("FAIL reset_dout got %0h exp 00", dout); end
    checks++; if (recv_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", recv_valid); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr got %0b exp 0", frame_err); end
    checks++; if (overrun_err !== 1'b0) begin errors++; $display("FAIL reset_oerr got %0b exp 0", overrun_err); end
    reset_n = 1'b1;
    idle(10);
  endtask

  task automatic test_basic_frame();
    int f0, o0;
    f0 = ferr_cnt; o0 = oerr_cnt;
    send_frame(8'hA5, 1'b1, 1'b0);
    checks++; if (rise_cyc !== start_cyc + STOP_LAT) begin errors++; $display("FAIL a5_latency got %0d exp %0d", rise_cyc - start_cyc, STOP_LAT); end
    checks++; if (dout !== 8'hA5) begin errors++; $display("FAIL a5_dout got %0h exp a5", dout); end
    checks++; if (recv_valid !== 1'b1) begin errors++; $display("FAIL a5_valid got %0b exp 1", recv_valid); end
    checks++; if (ferr_cnt !== f0) begin errors++; $display("FAIL a5_ferr got %0d exp %0d", ferr_cnt, f0); end
    checks++; if (oerr_cnt !== o0) begin errors++; $display("FAIL a5_oerr got %0d exp %0d", oerr_cnt, o0); end
    do_ack();
    checks++; if (recv_valid !== 1'b0) begin errors++; $display("FAIL a5_ack_clear got %0b exp 0", recv_valid); end
    idle(10);
  endtask

  task automatic test_glitch();
    int f0, o0;
    f0 = ferr_cnt; o0 = oerr_cnt;
    rx = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    idle(100);
    checks++; if (recv_valid !== 1'b0) begin errors++; $display("FAIL glitch_valid got %0b exp 0", recv_valid); end
    checks++; if (ferr_cnt !== f0) begin errors++; $display("FAIL glitch_ferr got %0d exp %0d", ferr_cnt, f0); end
    checks++; if (oerr_cnt !== o0) begin errors++; $display("FAIL glitch_oerr got %0d exp %0d", oerr_cnt, o0); end
    send_frame(8'h3C, 1'b1, 1'b0);
    checks++; if (dout !== 8'h3C) begin errors++; $display("FAIL 3c_dout got %0h exp 3c", dout); end
    checks++; if (recv_valid !== 1'b1) begin errors++; $display("FAIL 3c_valid got %0b exp 1", recv_valid); end
    do_ack();
    idle(10);
  endtask

  task automatic test_frame_error();
    int f0, o0;
    f0 = ferr_cnt; o0 = oerr_cnt;
    send_frame(8'h81, 1'b0, 1'b0);
    idle(100);
    checks++; if (ferr_cnt !== f0 + 1) begin errors++; $display("FAIL ferr_pulse got %0d exp %0d", ferr_cnt, f0 + 1); end
    checks++; if (recv_valid !== 1'b0) begin errors++; $display("FAIL ferr_valid got %0b exp 0", recv_valid); end
    checks++; if (dout !== 8'h3C) begin errors++; $display("FAIL ferr_dout got %0h exp 3c", dout); end
    checks++; if (oerr_cnt !== o0) begin errors++; $display("FAIL ferr_oerr got %0d exp %0d", oerr_cnt, o0); end
  endtask

  task automatic test_back_to_back();
    int f0, o0, o1;
    f0 = ferr_cnt; o0 = oerr_cnt;
    send_frame(8'h11, 1'b1, 1'b0);
    checks++; if (dout !== 8'h11) begin errors++; $display("FAIL b2b_first_dout got %0h exp 11", dout); end
    checks++; if (recv_valid !== 1'b1) begin errors++; $display("FAIL b2b_first_valid got %0b exp 1", recv_valid); end
    send_frame(8'h22, 1'b1, 1'b0);
    idle(10);
    checks++; if (dout !== 8'h11) begin errors++; $display("FAIL overrun_dout got %0h exp 11", dout); end
    checks++; if (recv_valid !== 1'b1) begin errors++; $display("FAIL overrun_valid got %0b exp 1", recv_valid); end
    checks++; if (oerr_cnt !== o0 + 1) begin errors++; $display("FAIL overrun_pulse got %0d exp %0d", oerr_cnt, o0 + 1); end
    o1 = oerr_cnt;
    send_frame(8'h22, 1'b1, 1'b1);
    idle(10);
    checks++; if (dout !== 8'h22) begin errors++; $display("FAIL ack_load_dout got %0h exp 22", dout); end
    checks++; if (recv_valid !== 1'b1) begin errors++; $display("FAIL ack_load_valid got %0b exp 1", recv_valid); end
    checks++; if (oerr_cnt !== o1) begin errors++; $display("FAIL ack_load_oerr got %0d exp %0d", oerr_cnt, o1); end
    checks++; if (ferr_cnt !== f0) begin errors++; $display("FAIL b2b_ferr got %0d exp %0d", ferr_cnt, f0); end
  endtask

  task automatic test_reset_mid_frame();
    int f0, o0;
    f0 = ferr_cnt; o0 = oerr_cnt;
    rx = 1'b0;
    repeat (BIT_CLKS) @(posedge clk);
    #1;
    rx = 1'b1;
    repeat (4 * BIT_CLKS + 30) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (dout !== 8'h00) begin errors++; $display("FAIL midrst_dout got %0h exp 00", dout); end
    checks++; if (recv_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got %0b exp 0", recv_valid); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL midrst_ferr got %0b exp 0", frame_err); end
    checks++; if (overrun_err !== 1'b0) begin errors++; $display("FAIL midrst_oerr got %0b exp 0", overrun_err); end
    repeat (5) @(posedge clk);
    #1;
    reset_n = 1'b1;
    idle(700);
    checks++; if (recv_valid !== 1'b0) begin errors++; $display("FAIL midrst_spurious_valid got %0b exp 0", recv_valid); end
    send_frame(8'h5A, 1'b1, 1'b0);
    checks++; if (dout !== 8'h5A) begin errors++; $display("FAIL 5a_dout got %0h exp 5a", dout); end
    checks++; if (recv_valid !== 1'b1) begin errors++; $display("FAIL 5a_valid got %0b exp 1", recv_valid); end
    checks++; if (ferr_cnt !== f0) begin errors++; $display("FAIL 5a_ferr got %0d exp %0d", ferr_cnt, f0); end
    checks++; if (oerr_cnt !== o0) begin errors++; $display("FAIL 5a_oerr got %0d exp %0d", oerr_cnt, o0); end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_glitch();
    test_frame_error();
    test_back_to_back();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 SHALL have parameter SYS_FREQ, default 50000000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 9600, line bit rate.
REQ-003 SHALL have parameter SAMPLE, default 16, oversampling ticks per bit; even, >= 4.
REQ-004 SHALL have parameter BAUD_DV, default SYS_FREQ/(SAMPLE*BAUD_RATE), clk cycles per sample tick; >= 2.
REQ-005 SHALL have parameter DATA_SIZE, default 8, data bits per frame.
REQ-006 SHALL have port clk, input, 1, system clock; all logic on its rising edge.
REQ-007 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port rx, input, 1, asynchronous serial line; idle high.
REQ-009 SHALL have port dout, output, DATA_SIZE, last accepted data word.
REQ-010 SHALL have port recv_valid, output, 1, level; dout holds an unconsumed word.
REQ-011 SHALL have port recv_ack, input, 1, consumer accepts dout while recv_valid is 1.
REQ-012 SHALL have port frame_err, output, 1, one-cycle pulse; stop bit sampled 0.
REQ-013 SHALL have port overrun_err, output, 1, one-cycle pulse; good frame arrived while recv_valid is 1 and no recv_ack.

Function
REQ-014 SHALL pass rx through a 2-flop synchronizer, reset value 1; all decisions use the synchronized value rx_s.
REQ-015 SHALL run a tick counter 0..BAUD_DV-1 with a one-cycle tick at BAUD_DV-1, held at 0 in IDLE.
REQ-016 SHALL use states IDLE, START, DATA, STOP; unused encodings go to IDLE.
REQ-017 In IDLE, rx_s=0 SHALL enter START and clear the tick, sample and bit counters.
REQ-018 In START, at tick number SAMPLE/2 (mid start bit), rx_s=1 SHALL return to IDLE (glitch rejected, no flag); rx_s=0 SHALL clear the sample counter and enter DATA.
REQ-019 In DATA, every SAMPLE ticks (mid-bit) SHALL shift rx_s into the shift register LSB-first (enter at MSB, shift right) and increment the bit counter.
REQ-020 After the DATA_SIZE-th data sample, SHALL enter STOP.
REQ-021 In STOP, at the SAMPLE-th tick (mid stop bit), SHALL return to IDLE in the same cycle, so a start bit following a minimum-length stop bit is caught.
REQ-022 Stop sample 1 with recv_valid=0, or recv_ack=1 in that cycle: SHALL load dout from the shift register and set recv_valid=1 on the next clk edge. This is one cycle of latency from the mid-stop tick.
REQ-023 Stop sample 1 with recv_valid=1 and recv_ack=0: SHALL keep the old dout and recv_valid, discard the new word, and pulse overrun_err for one cycle.
REQ-024 Stop sample 0: SHALL discard the word, pulse frame_err for one cycle, and leave dout and recv_valid unchanged.
REQ-025 recv_ack=1 while recv_valid=1 SHALL clear recv_valid on the next edge unless a new word loads in the same cycle (REQ-022), in which case recv_valid stays 1.
REQ-026 recv_ack while recv_valid=0 SHALL be ignored.
REQ-027 Counters SHALL be sized with $clog2 of their maximum count; the bit counter SHALL hold 0..DATA_SIZE without wrap.
REQ-028 The rx line SHALL be ignored outside sample points, except for start detection in IDLE.

Reset
REQ-029 On reset_n=0, asynchronously: state=IDLE, all counters 0, shift register 0, dout=0, recv_valid=0, frame_err=0, overrun_err=0, synchronizer flops=1.
REQ-030 Reset mid-frame SHALL abandon the frame with no flag; after release, the receiver SHALL wait for line idle-high and then a new falling edge before starting.
REQ-031 Outputs SHALL be registered; no combinational path from rx or recv_ack to any output.

Verification (SYS_FREQ=640, BAUD_RATE=10, SAMPLE=16, BAUD_DV=4, DATA_SIZE=8; bit = 64 clk)
REQ-032 Frame 0xA5, stop=1, recv_ack tied 0 -> recv_valid rises 1 clk after mid-stop tick, dout=0xA5, no error pulses.
REQ-033 rx low for 20 clk then high -> no recv_valid, no error, state back in IDLE; next clean frame 0x3C received correctly.
REQ-034 Frame 0x81 with stop bit 0 -> frame_err single-cycle pulse, recv_valid stays 0, dout unchanged.
REQ-035 Frames 0x11 then 0x22 back-to-back (1 stop bit), no ack -> dout=0x11, overrun_err pulses once. Then with recv_ack asserted exactly on the 0x22 stop-sample cycle -> dout=0x22, recv_valid stays 1, no overrun.
REQ-036 reset_n pulsed low at data bit 4 of frame 0xFF -> all outputs 0 immediately; next frame 0x5A received correctly with no spurious flags.
